// File: rtl/jp_multi.sv
// rtl/jp_multi.sv - multi-pad serial joypad scanner with CPU strobe/read port
module jp_multi #(
  parameter int          N_PADS   = 2,
  parameter int          N_BITS   = 8,
  parameter int          HALF     = 16,
  parameter int          GAP      = 256,
  parameter logic [15:0] MMR_BASE = 16'h4016
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr,
  input  logic [15:0]                addr,
  input  logic [7:0]                 din,
  input  logic [N_PADS-1:0]          jp_data,
  output logic                       jp_clk,
  output logic                       jp_latch,
  output logic [7:0]                 dout,
  output logic                       scan_done,
  output logic [N_PADS*N_BITS-1:0]   pad_state
);
  localparam int CMAX = (GAP > HALF) ? GAP : HALF;
  localparam int CW   = $clog2(CMAX + 1);
  localparam int IW   = $clog2(N_BITS);
  localparam int PW   = (N_PADS > 1) ? $clog2(N_PADS) : 1;

  typedef enum logic [2:0] {S_GAP, S_LATCH, S_LO, S_HI, S_DONE} state_t;

  state_t            state, state_n;
  logic [CW-1:0]     cnt, cnt_n;
  logic [IW-1:0]     idx, idx_n;
  logic              sample;
  logic              commit;
  logic [N_BITS-1:0] work [N_PADS];

  logic [15:0]       prev_addr;
  logic [15:0]       offset;
  logic [PW-1:0]     pad_sel;
  logic              in_range;
  logic              access;
  logic              wr_strobe;
  logic              rd_shift;
  logic              strobe;
  logic              strobe_fall;
  logic [N_BITS-1:0] shift_r [N_PADS];
  logic              unused_din;

  assign commit     = (state == S_DONE);
  assign unused_din = ^din[7:1];

  // Scan sequencer: phase counter per half-period, bit index across LO/HI pairs
  always_comb begin
    state_n = state;
    cnt_n   = cnt + CW'(1);
    idx_n   = idx;
    sample  = 1'b0;
    case (state)
      S_GAP: if (cnt == CW'(GAP - 1)) begin
        state_n = S_LATCH;
        cnt_n   = '0;
      end
      S_LATCH: if (cnt == CW'(HALF - 1)) begin
        state_n = S_LO;
        cnt_n   = '0;
        idx_n   = '0;
      end
      S_LO: if (cnt == CW'(HALF - 1)) begin
        sample = 1'b1;
        cnt_n  = '0;
        if (idx == IW'(N_BITS - 1)) begin
          state_n = S_DONE;
        end else begin
          idx_n   = idx + IW'(1);
          state_n = S_HI;
        end
      end
      S_HI: if (cnt == CW'(HALF - 1)) begin
        state_n = S_LO;
        cnt_n   = '0;
      end
      S_DONE: begin
        state_n = S_GAP;
        cnt_n   = '0;
      end
      default: begin
        state_n = S_GAP;
        cnt_n   = '0;
      end
    endcase
  end

  // Scan state, pad outputs decoded from next state so they are true flops, atomic commit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_GAP;
      cnt       <= '0;
      idx       <= '0;
      jp_clk    <= 1'b0;
      jp_latch  <= 1'b0;
      scan_done <= 1'b0;
      pad_state <= '0;
      for (int i = 0; i < N_PADS; i++) work[i] <= '0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      idx       <= idx_n;
      jp_latch  <= (state_n == S_LATCH);
      jp_clk    <= (state_n == S_HI);
      scan_done <= commit;
      for (int i = 0; i < N_PADS; i++) begin
        if (sample) work[i][idx] <= ~jp_data[i];
        if (commit) pad_state[i*N_BITS +: N_BITS] <= work[i];
      end
    end
  end

  // Address decode: an access is a fresh in-range address, repeats are ignored
  always_comb begin
    offset      = addr - MMR_BASE;
    pad_sel     = offset[PW-1:0];
    in_range    = (offset < 16'(N_PADS));
    access      = in_range && (addr != prev_addr);
    wr_strobe   = access && wr && (addr == MMR_BASE);
    rd_shift    = access && !wr && !strobe;
    strobe_fall = wr_strobe && strobe && !din[0];
  end

  // Strobe and per-pad read shift registers; a falling strobe loads the newest snapshot
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_addr <= '0;
      strobe    <= 1'b0;
      for (int i = 0; i < N_PADS; i++) shift_r[i] <= '0;
    end else begin
      prev_addr <= addr;
      if (wr_strobe) strobe <= din[0];
      for (int i = 0; i < N_PADS; i++) begin
        if (strobe_fall)
          shift_r[i] <= commit ? work[i] : pad_state[i*N_BITS +: N_BITS];
        else if (rd_shift && pad_sel == PW'(i))
          shift_r[i] <= {1'b1, shift_r[i][N_BITS-1:1]};
      end
    end
  end

  // Read data: live button A while strobed, otherwise the shift register head
  always_comb begin
    dout = 8'h00;
    for (int i = 0; i < N_PADS; i++) begin
      if (in_range && !wr && pad_sel == PW'(i))
        dout[0] = strobe ? pad_state[i*N_BITS] : shift_r[i][0];
    end
  end
endmodule

// File: tb/tb_jp_multi.sv
// tb/tb_jp_multi.sv - scoreboard bench for jp_multi with pad model and read model
module tb_jp_multi;
  localparam int          NP   = 2;
  localparam int          NB   = 8;
  localparam int          HF   = 4;
  localparam int          GP   = 8;
  localparam int          PER  = HF * 2 * NB + 1 + GP;
  localparam logic [15:0] BASE = 16'h4016;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              wr = 1'b0;
  logic [15:0]       addr = 16'h0000;
  logic [7:0]        din = 8'h00;
  logic [NP-1:0]     jp_data;
  logic              jp_clk, jp_latch, scan_done;
  logic [7:0]        dout;
  logic [NP*NB-1:0]  pad_state;

  jp_multi #(.N_PADS(NP), .N_BITS(NB), .HALF(HF), .GAP(GP), .MMR_BASE(BASE)) dut (
    .clk(clk), .rst(rst), .wr(wr), .addr(addr), .din(din), .jp_data(jp_data),
    .jp_clk(jp_clk), .jp_latch(jp_latch), .dout(dout), .scan_done(scan_done),
    .pad_state(pad_state)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc;

  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  // Pad model: parallel load while latched, shift on each rising pad clock, 1s afterwards
  logic [NB-1:0] buttons [NP];
  logic [NB-1:0] pad_sr [NP];
  logic          pclk_d = 1'b0;
  always @(posedge clk) begin
    pclk_d <= jp_clk;
    for (int i = 0; i < NP; i++) begin
      if (jp_latch)               pad_sr[i] <= buttons[i];
      else if (jp_clk && !pclk_d) pad_sr[i] <= pad_sr[i] >> 1;
    end
  end
  always_comb for (int i = 0; i < NP; i++) jp_data[i] = ~pad_sr[i][0];

  // Scoreboard queues
  typedef struct {int c; logic [NP*NB-1:0] st;} scan_t;
  scan_t      scan_q[$];
  logic [7:0] rd_q[$];
  logic       rd_chk = 1'b0;
  scan_t      s_pop;
  logic [7:0] r_pop;
  int latch_hi, clk_hi, clk_rise, first_latch;
  logic mclk_d;

  // Monitor: checks commits and reads whenever the DUT presents them
  always @(negedge clk) begin
    if (rst) begin
      latch_hi = 0; clk_hi = 0; clk_rise = 0; first_latch = -1; mclk_d = 1'b0;
    end else begin
      if (scan_done) begin
        if (scan_q.size() == 0) check("unexpected_scan_done", scan_done, 1'b0);
        else begin
          s_pop = scan_q.pop_front();
          check("scan_done_cycle", cyc, s_pop.c);
          check("pad_state", pad_state, s_pop.st);
        end
      end
      if (rd_chk) begin
        if (rd_q.size() == 0) check("read_without_expect", rd_chk, 1'b0);
        else begin
          r_pop = rd_q.pop_front();
          check("dout", dout, r_pop);
        end
      end
      if (cyc <= PER) begin
        if (jp_latch) latch_hi++;
        if (jp_latch && first_latch < 0) first_latch = cyc;
        if (jp_clk) clk_hi++;
        if (jp_clk && !mclk_d) clk_rise++;
      end
      mclk_d = jp_clk;
    end
  end

  // Reference model of the CPU-visible register file
  logic [NB-1:0] m_committed [NP];
  logic [NB-1:0] m_snap [NP];
  logic [NB-1:0] pend [NP];
  int            m_idx [NP];
  logic          m_strobe;
  int            nd;

  function automatic logic [7:0] model_read(input int p);
    logic b;
    if (m_strobe) b = m_committed[p][0];
    else begin
      b = (m_idx[p] < NB) ? m_snap[p][m_idx[p]] : 1'b1;
      m_idx[p]++;
    end
    return {7'b0, b};
  endfunction

  task automatic model_write(input logic [15:0] a, input logic [7:0] d);
    if (a == BASE) begin
      if (m_strobe && !d[0])
        for (int i = 0; i < NP; i++) begin m_snap[i] = m_committed[i]; m_idx[i] = 0; end
      m_strobe = d[0];
    end
  endtask

  task automatic model_reset();
    m_strobe = 1'b0;
    for (int i = 0; i < NP; i++) begin m_committed[i] = '0; m_snap[i] = '0; m_idx[i] = 0; end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic start_scan(input logic [NP*NB-1:0] flat);
    scan_t s;
    for (int i = 0; i < NP; i++) begin buttons[i] = flat[i*NB +: NB]; pend[i] = flat[i*NB +: NB]; end
    nd += PER;
    s.c = nd; s.st = flat;
    scan_q.push_back(s);
  endtask

  task automatic wait_scan();
    int n = 0;
    do begin @(negedge clk); n++; end while (!scan_done && n < 3 * PER);
    check("scan_done_seen", scan_done, 1'b1);
    for (int i = 0; i < NP; i++) m_committed[i] = pend[i];
    tick();
  endtask

  task automatic do_write(input logic [15:0] a, input logic [7:0] d);
    model_write(a, d);
    addr = a; wr = 1'b1; din = d; tick();
    wr = 1'b0; addr = 16'h0000; din = 8'h00; tick();
  endtask

  task automatic do_read(input int p);
    rd_q.push_back(model_read(p));
    addr = BASE + 16'(p); wr = 1'b0; rd_chk = 1'b1; tick();
    rd_chk = 1'b0; addr = 16'h0000; tick();
  endtask

  task automatic check_first_scan();
    check("latch_high_cycles", latch_hi, HF);
    check("jp_clk_pulses", clk_rise, NB - 1);
    check("jp_clk_high_cycles", clk_hi, HF * (NB - 1));
    check("first_latch_cycle", first_latch, GP);
  endtask

  task automatic random_reads(input int n);
    for (int k = 0; k < n; k++) do_read($urandom_range(0, NP - 1));
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < NP; i++) begin buttons[i] = '0; pad_sr[i] = '0; pend[i] = '0; end
    model_reset();
    nd = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_jp_clk", jp_clk, 1'b0);
    check("rst_jp_latch", jp_latch, 1'b0);
    check("rst_scan_done", scan_done, 1'b0);
    check("rst_pad_state", pad_state, '0);
    addr = BASE; #1;
    check("rst_dout", dout, 8'h00);
    addr = 16'h0000;
    @(negedge clk); rst = 1'b0;

    // Scan 1: pad0 A and bit7 pressed, pad1 idle
    start_scan({8'h00, 8'h81});
    wait_scan();
    check_first_scan();
    start_scan({8'hA5, 8'h5B});
    do_write(BASE, 8'h01);
    do_write(BASE, 8'h00);
    for (int k = 0; k < 10; k++) do_read(0);

    // Scan 2: strobe held returns live A, then held-address single shift
    wait_scan();
    start_scan(16'($urandom));
    do_write(BASE, 8'h01);
    for (int k = 0; k < 3; k++) do_read(0);
    do_write(BASE, 8'h00);
    do_read(0);
    do_read(0);
    rd_q.push_back(model_read(1));
    addr = BASE + 16'd1; wr = 1'b0; rd_chk = 1'b1; tick();
    rd_chk = 1'b0;
    repeat (4) tick();
    addr = 16'h0000; tick();
    do_read(1);
    do_read(1);
    do_write(BASE + 16'd1, 8'h01);
    do_read(1);
    do_read(1);

    // Scan 3: random reads, then strobe falls exactly on the next commit
    wait_scan();
    start_scan({8'($urandom), 8'h3C});
    do_write(BASE, 8'h01);
    do_write(BASE, 8'h00);
    random_reads(2 * NB + 2);
    do_write(BASE, 8'h01);
    for (int k = 0; k < 3 * PER && cyc != nd - 1; k++) tick();
    check("sync_done_cycle", cyc, nd - 1);
    for (int i = 0; i < NP; i++) m_committed[i] = pend[i];
    model_write(BASE, 8'h00);
    addr = BASE; wr = 1'b1; din = 8'h00; tick();
    wr = 1'b0; addr = 16'h0000; tick();
    start_scan(16'($urandom));
    for (int k = 0; k < NB; k++) do_read(0);
    random_reads(6);

    // Reset in the middle of a scan while the pad clock is high
    for (int k = 0; k < 3 * PER && !jp_clk; k++) @(negedge clk);
    check("saw_jp_clk_high", jp_clk, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("midrst_jp_clk", jp_clk, 1'b0);
    check("midrst_jp_latch", jp_latch, 1'b0);
    check("midrst_pad_state", pad_state, '0);
    addr = BASE; #1;
    check("midrst_dout", dout, 8'h00);
    addr = 16'h0000;
    scan_q.delete();
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    nd = 0;
    start_scan(16'($urandom));
    for (int k = 0; k < 100 && cyc < GP - 1; k++) tick();
    check("pre_latch_low", jp_latch, 1'b0);
    tick();
    check("latch_after_gap", jp_latch, 1'b1);
    wait_scan();
    check_first_scan();
    do_write(BASE, 8'h01);
    do_write(BASE, 8'h00);
    random_reads(10);
    tick();
    check("reads_drained", rd_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
